// File: rtl/niosii_system_sysid_checker_pkg.sv
// -----------------------------------------------------------------------------
// sysid_checker_pkg
//   Shared definitions for the Nios II system-ID checker: the FSM state
//   encoding, the Avalon-MM word offsets of the sysid slave and the width of
//   the per-read stall counter.
// -----------------------------------------------------------------------------
package sysid_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Word offsets inside the sysid slave.
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Stall counter width; covers TIMEOUT_CYCLES up to 65535.
    localparam int STALL_W = 16;

endpackage

// File: rtl/niosii_system_sysid_checker_timer.sv
// -----------------------------------------------------------------------------
// niosii_system_sysid_checker_timer
//   Saturating stall counter for one Avalon-MM read.
//   Ports:
//     clock, reset_n : rising-edge clock, asynchronous active-low reset
//     clear          : synchronous clear (wins over enable)
//     enable         : count this cycle (slave is stalling)
//     limit          : number of stalled cycles allowed per read (>= 1)
//     expired        : this stalled cycle is the limit-th consecutive one
// -----------------------------------------------------------------------------
module niosii_system_sysid_checker_timer
    import sysid_checker_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [STALL_W-1:0] limit,
    output logic               expired
);

    logic [STALL_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            // Saturates at all-ones instead of wrapping.
            count <= count + 1'b1;
        end
    end

    // count holds the stalls already seen, so the current stall is number
    // count+1; flag it when that reaches the limit.
    assign expired = enable && (count >= (limit - 1'b1));

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// niosii_system_sysid_checker
//   On a start request, reads the system ID (offset 0) and, optionally, the
//   build timestamp (offset 1) from an Avalon-MM sysid slave with zero read
//   latency, compares them against the expected values and reports the result
//   with a one-cycle done pulse. A stalled read that exceeds TIMEOUT_CYCLES is
//   abandoned and flagged as a timeout.
//   Ports:
//     clock, reset_n         : rising-edge clock, asynchronous active-low reset
//     start                  : request one check sequence (honoured in IDLE only)
//     avm_address, avm_read  : Avalon-MM master request (registered)
//     avm_readdata           : read data, valid when avm_waitrequest = 0
//     avm_waitrequest        : slave stall
//     busy, done             : sequence active / one-cycle completion pulse
//     id_ok, ts_ok, timeout  : comparison results and timeout flag
//     id_value, ts_value     : values read back (0 when not read)
// -----------------------------------------------------------------------------
module niosii_system_sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1485636471,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        read_d, addr_d;
    logic        id_ok_d, ts_ok_d, timeout_d;
    logic [31:0] id_value_d, ts_value_d;
    logic        timer_clear, stall_en, stall_expired, finish;

    assign stall_en = ((state_q == RD_ID) || (state_q == RD_TS)) && avm_waitrequest;

    niosii_system_sysid_checker_timer u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (stall_en),
        .limit   (STALL_LIMIT),
        .expired (stall_expired)
    );

    // Next-state and next-output logic. Every output is a flop loaded from
    // these *_d values, so all outputs are registered.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        read_d      = avm_read;
        addr_d      = avm_address;
        id_ok_d     = id_ok;
        ts_ok_d     = ts_ok;
        timeout_d   = timeout;
        id_value_d  = id_value;
        ts_value_d  = ts_value;
        timer_clear = 1'b0;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RD_ID;
                    read_d      = 1'b1;
                    addr_d      = ADDR_ID;
                    id_ok_d     = 1'b0;
                    ts_ok_d     = 1'b0;
                    timeout_d   = 1'b0;
                    id_value_d  = '0;
                    ts_value_d  = '0;
                    timer_clear = 1'b1;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    id_value_d = avm_readdata;
                    if (CHECK_TS) begin
                        state_d     = RD_TS;
                        addr_d      = ADDR_TS;
                        timer_clear = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end else if (stall_expired) begin
                    timeout_d = 1'b1;
                    finish    = 1'b1;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_value_d = avm_readdata;
                    finish     = 1'b1;
                end else if (stall_expired) begin
                    timeout_d = 1'b1;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entering DONE: drop the read and evaluate against the values being
        // loaded on this same edge.
        if (finish) begin
            state_d = DONE;
            read_d  = 1'b0;
            id_ok_d = (id_value_d == EXPECTED_ID) && !timeout_d;
            ts_ok_d = CHECK_TS ? ((ts_value_d == EXPECTED_TS) && !timeout_d)
                               : !timeout_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state_q     <= state_d;
            avm_read    <= read_d;
            avm_address <= addr_d;
            busy        <= (state_d != IDLE);
            done        <= (state_d == DONE);
            id_ok       <= id_ok_d;
            ts_ok       <= ts_ok_d;
            timeout     <= timeout_d;
            id_value    <= id_value_d;
            ts_value    <= ts_value_d;
        end
    end

endmodule

// File: doc/niosii_system_sysid_checker.md
NIOSII_SYSTEM_SYSID_CHECKER -- requirements
Module: niosII_system_sysid_checker

Interface
REQ-001 The block SHALL have parameter EXPECTED_ID, default 32'd0, the system ID value that must be read at offset 0.
REQ-002 The block SHALL have parameter EXPECTED_TS, default 32'd1485636471, the timestamp value that must be read at offset 1.
REQ-003 The block SHALL have parameter CHECK_TS, default 1; when 0, the timestamp read is skipped.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535: the maximum number of consecutive stalled cycles per read.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: request one check sequence.
REQ-008 The block SHALL have port avm_address, output, 1 bit: Avalon-MM word address (0 = ID, 1 = timestamp).
REQ-009 The block SHALL have port avm_read, output, 1 bit: Avalon-MM read request.
REQ-010 The block SHALL have port avm_readdata, input, 32 bits: Avalon-MM read data.
REQ-011 The block SHALL have port avm_waitrequest, input, 1 bit: slave stall.
REQ-012 The block SHALL have output ports busy (1), done (1), id_ok (1), ts_ok (1), timeout (1), id_value (32) and ts_value (32).

Function
REQ-013 The block SHALL implement FSM states IDLE, RD_ID, RD_TS and DONE, with all outputs registered.
REQ-014 In IDLE, start=1 SHALL cause a transition to RD_ID on the next edge and clear id_ok, ts_ok, timeout, id_value and ts_value.
REQ-015 start SHALL be ignored in any state other than IDLE.
REQ-016 In RD_ID and RD_TS, the block SHALL drive avm_read=1 and avm_address=0 or 1 respectively, holding both stable while avm_waitrequest=1.
REQ-017 Read completion SHALL occur in a cycle with avm_read=1 and avm_waitrequest=0, with zero read latency: avm_readdata is captured in that same cycle.
REQ-018 On RD_ID completion, the block SHALL load id_value and go to RD_TS if CHECK_TS=1, else to DONE.
REQ-019 On RD_TS completion, the block SHALL load ts_value and go to DONE.
REQ-020 The per-read stall counter SHALL clear on entry to each read state and increment on each cycle with avm_waitrequest=1.
REQ-021 After TIMEOUT_CYCLES consecutive stalled cycles in a read state, the block SHALL deassert avm_read, set timeout=1 and go to DONE, leaving the unread value(s) at 0.
REQ-022 The stall counter SHALL saturate and never wrap.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-024 On entering DONE, id_ok SHALL be set to (id_value==EXPECTED_ID) and not timeout.
REQ-025 On entering DONE, ts_ok SHALL be set to (ts_value==EXPECTED_TS) and not timeout, forced to 1 when CHECK_TS=0 and no timeout occurred.
REQ-026 Results SHALL be held until the next accepted start.
REQ-027 busy SHALL be 1 in RD_ID, RD_TS and DONE, and 0 in IDLE.
REQ-028 With a zero-wait slave, a start sampled at cycle 0 SHALL produce RD_ID at cycle 1, RD_TS at cycle 2 and done at cycle 3; each wait cycle adds one cycle.
REQ-029 avm_read SHALL never be asserted in IDLE or DONE.

Reset
REQ-030 While reset_n=0, the FSM SHALL be in IDLE, and avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value and the stall counter SHALL all be 0.
REQ-031 Reset asserted mid-read SHALL deassert avm_read immediately (asynchronously) and abandon the transaction without a done pulse.
REQ-032 After reset release, the block SHALL accept start on the first clock edge.

Structure
REQ-033 Package sysid_checker_pkg SHALL hold the state enum, the offsets ADDR_ID=0 and ADDR_TS=1, and the stall counter width (16).
REQ-034 The stall counter SHALL be a sub-module, niosII_system_sysid_checker_timer, with clear, enable, limit and expired signals.
REQ-035 The remainder of the block SHALL be a single FSM with its datapath registers.

Verification
REQ-036 Zero-wait slave returning 0 and 1485636471, start pulse at cycle 0 -> done=1 at cycle 3, id_ok=1, ts_ok=1, timeout=0.
REQ-037 Slave with 3 wait cycles per read -> address and read stable during stalls, done at cycle 9, id_ok=1, ts_ok=1.
REQ-038 Slave returning 1485636470 at offset 1 -> done at cycle 3, ts_value=1485636470, ts_ok=0, id_ok=1.
REQ-039 TIMEOUT_CYCLES=8 with waitrequest stuck at 1 -> avm_read held for cycles 1-8, timeout=1, done at cycle 9, id_ok=0, ts_ok=0.
REQ-040 reset_n low at cycle 2 of a stalled read -> avm_read=0 immediately, no done pulse, all outputs 0; a new start after release completes normally.
REQ-041 start re-pulsed at cycles 1 and 2 of a sequence -> ignored, exactly one done pulse, and CHECK_TS=0 run -> done at cycle 2 with ts_ok=1.
